// File: rtl/lsq_mem_arbiter.sv
// lsq_mem_arbiter: shares one non-pipelined dmem port between the store-queue head and
// the load issue path, sequencing each access and bounding store starvation.
module lsq_mem_arbiter #(
   parameter int TAG_W        = 6,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             st_valid,
   input  logic             st_commit_ok,
   input  logic [31:0]      st_addr,
   input  logic [3:0]       st_wmask,
   input  logic [31:0]      st_wdata,
   output logic             st_dequeue,
   input  logic             ld_valid,
   input  logic [31:0]      ld_addr,
   input  logic [3:0]       ld_rmask,
   input  logic [TAG_W-1:0] ld_tag,
   output logic             ld_ack,
   output logic             ld_result_valid,
   output logic [TAG_W-1:0] ld_result_tag,
   output logic [31:0]      ld_result_data,
   output logic [31:0]      dmem_addr,
   output logic [3:0]       dmem_rmask,
   output logic [3:0]       dmem_wmask,
   output logic [31:0]      dmem_wdata,
   input  logic             dmem_resp,
   input  logic [31:0]      dmem_rdata
);
   typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   state_t state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic squash_q, squash_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic st_elig, ld_elig, idle, st_win, ld_win, res_v;
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{ld_addr[1:0], st_addr[1:0]};
   always_comb begin
      st_elig = st_valid & st_commit_ok;
      ld_elig = ld_valid & ~flush;
      // Outputs stay quiet while rst is held, so arbitration is gated by it too.
      idle = (state_q == IDLE) & ~rst;
      st_win = idle & st_elig & (~ld_elig | (starve_q == LIMIT));
      ld_win = idle & ld_elig & ~st_win;
      res_v = (state_q == LD_WAIT) & dmem_resp & ~squash_q & ~flush & ~rst;
      state_d = state_q;
      if (ld_win) state_d = LD_WAIT;
      else if (st_win) state_d = ST_WAIT;
      else if (state_q != IDLE && dmem_resp) state_d = IDLE;
      squash_d = ld_win ? 1'b0 : ((state_q == LD_WAIT) & flush) | squash_q;
      starve_d = st_win ? 4'd0
               : (ld_win & st_elig & (starve_q != LIMIT)) ? starve_q + 4'd1 : starve_q;
      tag_d = ld_win ? ld_tag : tag_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         starve_q <= '0;
         squash_q <= 1'b0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         squash_q <= squash_d;
         tag_q    <= tag_d;
      end
   end
   assign ld_ack          = ld_win;
   assign st_dequeue      = st_win;
   assign dmem_rmask      = ld_win ? ld_rmask : '0;
   assign dmem_wmask      = st_win ? st_wmask : '0;
   assign dmem_wdata      = st_win ? st_wdata : '0;
   assign dmem_addr       = ld_win ? {ld_addr[31:2], 2'b00} : st_win ? {st_addr[31:2], 2'b00} : '0;
   assign ld_result_valid = res_v;
   assign ld_result_tag   = res_v ? tag_q : '0;
   assign ld_result_data  = res_v ? dmem_rdata : '0;
endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// tb_lsq_mem_arbiter: directed vector table, starvation sequence and randomized run
// against a transaction-level model of the arbiter.
module tb_lsq_mem_arbiter;
   localparam int TAG_W = 6;
   localparam int LIMIT = 4;
   localparam logic [31:0] SADDR = 32'h0000_2003, SDATA = 32'hCAFE_F00D, LADDR = 32'h0000_1006;
   logic clk = 1'b0;
   logic rst, flush, st_valid, st_commit_ok, st_dequeue, ld_valid, ld_ack;
   logic ld_result_valid, dmem_resp;
   logic [31:0] st_addr, st_wdata, ld_addr, ld_result_data, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0] st_wmask, ld_rmask, dmem_rmask, dmem_wmask;
   logic [TAG_W-1:0] ld_tag, ld_result_tag;
   always #5 clk = ~clk;
   lsq_mem_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .st_valid(st_valid), .st_commit_ok(st_commit_ok), .st_addr(st_addr),
      .st_wmask(st_wmask), .st_wdata(st_wdata), .st_dequeue(st_dequeue),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_tag(ld_tag),
      .ld_ack(ld_ack), .ld_result_valid(ld_result_valid), .ld_result_tag(ld_result_tag),
      .ld_result_data(ld_result_data), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
      .dmem_rdata(dmem_rdata)
   );
   logic [112:0] act;
   assign act = {ld_ack, st_dequeue, ld_result_valid, ld_result_tag, ld_result_data,
                 dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata};
   int checks = 0, errors = 0;
   typedef struct {
      bit rst, flush, stv, stok, ldv, resp;
      logic [TAG_W-1:0] tag;
      logic [31:0] rdata;
      bit ack, deq, rv;
      logic [TAG_W-1:0] rtag;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t mk(bit r, bit f, bit sv, bit so, bit lv, bit rs, logic [TAG_W-1:0] tg,
                               logic [31:0] rd, bit a, bit d, bit v, logic [TAG_W-1:0] rt);
      vec_t x;
      x.rst = r; x.flush = f; x.stv = sv; x.stok = so; x.ldv = lv; x.resp = rs;
      x.tag = tg; x.rdata = rd; x.ack = a; x.deq = d; x.rv = v; x.rtag = rt;
      return x;
   endfunction
   function automatic logic [112:0] exp_of(bit a, bit d, bit v, logic [TAG_W-1:0] rt,
                                           logic [31:0] rd, logic [31:0] la, logic [3:0] lm,
                                           logic [31:0] sa, logic [3:0] sm, logic [31:0] sd);
      logic [31:0] ea;
      ea = a ? {la[31:2], 2'b00} : d ? {sa[31:2], 2'b00} : 32'd0;
      return {a, d, v, v ? rt : 6'd0, v ? rd : 32'd0, ea, a ? lm : 4'd0, d ? sm : 4'd0,
              d ? sd : 32'd0};
   endfunction
   task automatic chk(input string nm, input logic [112:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic apply(input vec_t v, input string nm);
      rst = v.rst; flush = v.flush; st_valid = v.stv; st_commit_ok = v.stok;
      ld_valid = v.ldv; dmem_resp = v.resp; ld_tag = v.tag; dmem_rdata = v.rdata;
      ld_addr = LADDR; ld_rmask = 4'hC; st_addr = SADDR; st_wmask = 4'hF; st_wdata = SDATA;
      @(negedge clk);
      chk(nm, exp_of(v.ack, v.deq, v.rv, v.rtag, v.rdata, LADDR, 4'hC, SADDR, 4'hF, SDATA));
      @(posedge clk);
      #1;
   endtask
   int busy, starve;
   bit squash, ste, lde, sw, lw, rv;
   logic [TAG_W-1:0] mtag;
   initial begin
      rst = 1'b1; flush = 1'b0; st_valid = 1'b0; st_commit_ok = 1'b0; ld_valid = 1'b0;
      dmem_resp = 1'b0; ld_tag = '0; dmem_rdata = '0; ld_addr = '0; ld_rmask = '0;
      st_addr = '0; st_wmask = '0; st_wdata = '0;
      // reset, idle, lone load
      tbl.push_back(mk(1,0,1,1,1,0, 6'd7, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(1,0,0,0,0,0, 6'd0, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,1,0, 6'd5, 32'd0,          1,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,0, 6'd0, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,0, 6'd0, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'hDEADBEEF,   0,0,1, 6'd5));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'h5555AAAA,   0,0,0, 6'd0));
      // store gated by commit
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1,0,0,0, 6'd0, 32'd0, 0,0,0, 6'd0));
      tbl.push_back(mk(0,0,1,1,0,0, 6'd0, 32'd0,          0,1,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'h12345678,   0,0,0, 6'd0));
      // flush in flight, then a normal load
      tbl.push_back(mk(0,0,0,0,1,0, 6'd9, 32'd0,          1,0,0, 6'd0));
      tbl.push_back(mk(0,1,0,0,0,0, 6'd0, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,0, 6'd0, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'h11111111,   0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,1,0, 6'd10, 32'd0,         1,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'h22222222,   0,0,1, 6'd10));
      // flush in idle with committed store pending
      tbl.push_back(mk(0,1,1,1,1,0, 6'd1, 32'd0,          0,1,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'd0,          0,0,0, 6'd0));
      // reset during LD_WAIT
      tbl.push_back(mk(0,0,0,0,1,0, 6'd3, 32'd0,          1,0,0, 6'd0));
      tbl.push_back(mk(1,0,0,0,1,0, 6'd3, 32'd0,          0,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,1,0, 6'd4, 32'd0,          1,0,0, 6'd0));
      tbl.push_back(mk(0,0,0,0,0,1, 6'd0, 32'h33333333,   0,0,1, 6'd4));
      @(posedge clk);
      #1;
      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
      // starvation: 4 loads then 1 store, twice, with resp one cycle after issue
      for (int k = 0; k < 10; k++) begin
         bit is_st;
         is_st = (k % 5) == 4;
         apply(mk(0,0,1,1,1,0, 6'(k), 32'd0, !is_st, is_st, 0, 6'd0),
               $sformatf("starve_issue%0d", k));
         apply(mk(0,0,1,1,1,1, 6'(k + 20), 32'(32'h01010101 * k), 0, 0, !is_st, 6'(k)),
               $sformatf("starve_resp%0d", k));
      end
      // randomized run against the transaction model
      busy = 0; starve = 0; squash = 0; mtag = '0;
      for (int i = 0; i < 3000; i++) begin
         rst = (i == 0) || ($urandom_range(63) == 0);
         flush = $urandom_range(7) == 0;
         st_valid = 1'($urandom_range(1));
         st_commit_ok = 1'($urandom_range(1));
         ld_valid = 1'($urandom_range(1));
         dmem_resp = $urandom_range(2) == 0;
         ld_addr = $urandom; ld_rmask = 4'($urandom); ld_tag = 6'($urandom);
         st_addr = $urandom; st_wmask = 4'($urandom); st_wdata = $urandom;
         dmem_rdata = $urandom;
         ste = st_valid && st_commit_ok;
         lde = ld_valid && !flush;
         sw = !rst && busy == 0 && ste && (!lde || starve == LIMIT);
         lw = !rst && busy == 0 && lde && !sw;
         rv = !rst && busy == 1 && dmem_resp && !squash && !flush;
         @(negedge clk);
         chk($sformatf("rand%0d", i), exp_of(lw, sw, rv, mtag, dmem_rdata, ld_addr, ld_rmask,
                                            st_addr, st_wmask, st_wdata));
         if (rst) begin
            busy = 0; starve = 0; squash = 0; mtag = '0;
         end else if (lw) begin
            busy = 1; squash = 0; mtag = ld_tag;
            if (ste) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         end else if (sw) begin
            busy = 2; starve = 0;
         end else if (busy != 0) begin
            if (busy == 1 && flush) squash = 1;
            if (dmem_resp) busy = 0;
         end
         @(posedge clk);
         #1;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
